// File: rtl/ula_seq.sv
// ula_seq: registered ALU with start/busy/done handshake and multi-cycle shift-add unsigned multiply
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             c,
  output logic             ov,
  output logic             z,
  output logic             n
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand, alu_s;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH:0] add_w, sub_w, sum;
  logic accept, is_mul, last, alu_c, alu_ov;
  assign accept = start && state != RUN;
  assign is_mul = op == 3'b110;
  assign last = cnt == CW'(1);
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  // low accumulator half holds the multiplier and drains out as the product shifts in
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {sum, acc[WIDTH-1:1]};
  always_comb begin
    alu_s = '0;
    alu_c = 1'b0;
    alu_ov = 1'b0;
    case (op)
      3'b000: begin
        alu_s = add_w[M:0];
        alu_c = add_w[WIDTH];
        alu_ov = (a[M] == b[M]) && (add_w[M] != a[M]);
      end
      3'b001: alu_s = a & b;
      3'b010: alu_s = a | b;
      3'b011: alu_s = ~a;
      3'b100: begin
        alu_s = sub_w[M:0];
        alu_c = sub_w[WIDTH];
        alu_ov = (a[M] != b[M]) && (sub_w[M] != a[M]);
      end
      3'b101: alu_s = a ^ b;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (accept ? (is_mul ? RUN : DONE) : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc <= '0;
      cnt <= '0;
      s <= '0;
      s_hi <= '0;
      c <= 1'b0;
      ov <= 1'b0;
      z <= 1'b0;
      n <= 1'b0;
    end else if (accept && is_mul) begin
      mcand <= a;
      acc <= {{WIDTH{1'b0}}, b};
      cnt <= CW'(WIDTH);
    end else if (accept) begin
      s <= alu_s;
      s_hi <= '0;
      c <= alu_c;
      ov <= alu_ov;
      z <= alu_s == '0;
      n <= alu_s[M];
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= cnt - CW'(1);
      if (last) begin
        s <= acc_nx[M:0];
        s_hi <= acc_nx[2*WIDTH-1:WIDTH];
        c <= |acc_nx[2*WIDTH-1:WIDTH];
        ov <= 1'b0;
        z <= acc_nx == '0;
        n <= acc_nx[2*WIDTH-1];
      end
    end
  end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Registered, parametrised-width successor to the 8-bit combinational ULA. It extends the x/y op set (ADD/AND/OR/NOT) with SUB, XOR and an unsigned multi-cycle shift-add multiply. All outputs and flags are registered, and operations use a start/busy/done handshake. It sits in the Multiplicador datapath as the shared arithmetic unit feeding the multiplier-based blocks.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk     input   1        system clock, rising edge
rst_n   input   1        asynchronous active-low reset
start   input   1        request; sampled only when not busy
op      input   3        operation select, sampled with start
a       input   WIDTH    operand A, sampled with start
b       input   WIDTH    operand B, sampled with start
busy    output  1        multiply in progress; start is ignored while high
done    output  1        one-cycle pulse; result and flags valid from this cycle
s       output  WIDTH    result; low half of the product for MUL
s_hi    output  WIDTH    high half of the product for MUL; 0 for all other ops
c       output  1        carry/no-borrow flag; product-overflow flag for MUL
ov      output  1        signed overflow flag
z       output  1        zero flag
n       output  1        negative flag (MSB of the result)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0; s, s_hi, c, ov, z, n = 0; accumulator and counter cleared. Reset mid-MUL aborts the multiply with no done pulse.
- Op encoding: 000 ADD, 001 AND, 010 OR, 011 NOT a (b ignored), 100 SUB (a-b), 101 XOR, 110 MUL (unsigned), 111 reserved.
- FSM states are IDLE, RUN and DONE. DONE lasts exactly one cycle and accepts start exactly as IDLE does (back-to-back issue).
- IDLE/DONE with start=1 and op!=110: compute combinationally from a and b, register the result, next state DONE. start high in cycle 0 gives done=1 in cycle 1.
- IDLE/DONE with start=1 and op=110: latch a and b, clear the 2*WIDTH accumulator, set cnt=WIDTH, next state RUN, busy=1.
- RUN: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half with carry, then shift right by one. cnt decrements each cycle. On the cycle where cnt==1, perform the final iteration, write the outputs, and go to DONE with busy=0. start in cycle 0 gives done in cycle WIDTH+1 (cycle 9 for WIDTH=8).
- Outputs s, s_hi and the flags update only on entry to DONE and hold their values otherwise, including throughout RUN.
- start while busy=1 is ignored; the ignored request is not queued.
- done falls after one cycle unless a new non-MUL start is sampled in the DONE cycle. In that case done stays high for a second, consecutive cycle carrying the new result.
- ADD: {c,s} = a+b (WIDTH+1 bits). ov = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).
- SUB: {c,s} = a + ~b + 1, so c=1 means no borrow. ov = (a[MSB]!=b[MSB]) && (s[MSB]!=a[MSB]).
- AND/OR/XOR/NOT: c=0, ov=0.
- Non-MUL ops: z = (s==0), n = s[MSB], s_hi=0.
- MUL: {s_hi,s} = a*b. c = (s_hi!=0), ov=0, z = ({s_hi,s}==0), n = s_hi[MSB].
- Reserved op 111: completes like a non-MUL op with s=0, c=0, ov=0, z=1, n=0.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, ADD a=127, b=1, start in cycle 0 -> cycle 1: done=1, s=0x80, c=0, ov=1, z=0, n=1. Cycle 2: done=0 and outputs hold.
- ADD a=0x80, b=0x80 -> s=0x00, c=1, ov=1, z=1, n=0. SUB a=5, b=7 -> s=0xFE, c=0, ov=0, n=1. SUB a=0x80, b=1 -> s=0x7F, ov=1.
- AND/OR/XOR/NOT with a=0xCC, b=0xAA -> s=0x88, 0xEE, 0x66, 0x33 respectively; c=0 and ov=0 for all four.
- MUL a=0xFF, b=0xFF, start in cycle 0 -> busy=1 in cycles 1-8. Cycle 9: done=1, busy=0, s_hi=0xFE, s=0x01, c=1, n=1. Prior s/flags held through cycles 1-8. A start (ADD) pulsed in cycle 4 is ignored.
- MUL 0x00*0x5A -> z=1, c=0. MUL 3*5 -> s=0x0F, s_hi=0, c=0. In the done cycle, a new ADD 1+1 start -> done high in two consecutive cycles, s=0x02 in the second.
- rst_n low in cycle 5 of a MUL (asynchronous, between clock edges) -> all outputs 0 immediately, no done pulse. After release, ADD 2+3 -> s=5 one cycle after its start.
